// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Serves one load/store element at a time; refills and writes via RAM port.
module data_cache #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int BYTE_SIZE        = 8,
  parameter int CACHE_SIZE       = 16,
  parameter int CACHE_INDEX_SIZE = 4,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cache_vis_signal,
  input  logic [ADDR_WIDTH-1:0]   mem_vis_addr,
  input  logic [2:0]              d_cache_data_type,
  input  logic [LEN-1:0]          cache_written_data,
  input  logic [ENTRY_INDEX_SIZE:0] write_length,
  output logic [LEN-1:0]          mem_data,
  output logic [1:0]              d_cache_status,
  output logic                    ram_req,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-3:0]   ram_addr,
  output logic [LEN-1:0]          ram_wdata,
  output logic [3:0]              ram_wstrb,
  input  logic [LEN-1:0]          ram_rdata,
  input  logic                    ram_ready
);

  localparam logic [1:0] D_CACHE_NOP   = 2'b00;
  localparam logic [1:0] D_CACHE_LOAD  = 2'b01;
  localparam logic [1:0] D_CACHE_STORE = 2'b10;

  localparam logic [2:0] ONE_BYTE  = 3'b000;
  localparam logic [2:0] TWO_BYTE  = 3'b001;
  localparam logic [2:0] FOUR_BYTE = 3'b010;

  localparam logic [1:0] D_CACHE_RESTING = 2'b00;
  localparam logic [1:0] D_CACHE_WORKING = 2'b01;
  localparam logic [1:0] L_S_FINISHED    = 2'b10;

  localparam int TAG_W = ADDR_WIDTH - CACHE_INDEX_SIZE - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LEN-1:0]        mem_data_q, mem_data_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            type_q;
  logic [LEN-1:0]        wdata_q;
  logic                  store_q;

  logic [CACHE_SIZE-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [CACHE_SIZE];
  logic [LEN-1:0]        data_q [CACHE_SIZE];

  logic [CACHE_INDEX_SIZE-1:0] idx;
  logic [TAG_W-1:0]            tag;
  logic [1:0]                  lane;
  logic                        hit;
  logic                        type_ok;
  logic [LEN-1:0]              line;
  logic [LEN-1:0]              st_word;
  logic [3:0]                  st_strb;
  logic [LEN-1:0]              merged;
  logic                        fill, merge;
  logic                        unused_w;

  assign idx  = addr_q[CACHE_INDEX_SIZE+1:2];
  assign tag  = addr_q[ADDR_WIDTH-1:CACHE_INDEX_SIZE+2];
  assign lane = addr_q[1:0];
  assign line = data_q[idx];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);

  assign type_ok = (type_q == ONE_BYTE) ||
                   (type_q == TWO_BYTE) ||
                   (type_q == FOUR_BYTE);

  assign unused_w = ^write_length;

  // Pick the addressed element out of a word, zero-extended
  function automatic logic [LEN-1:0] extract(
    input logic [LEN-1:0] w,
    input logic [2:0]     t,
    input logic [1:0]     ln
  );
    logic [LEN-1:0] r;
    r = '0;
    unique case (1'b1)
      t == ONE_BYTE: r[BYTE_SIZE-1:0] = w[BYTE_SIZE*ln +: BYTE_SIZE];
      t == TWO_BYTE: r[2*BYTE_SIZE-1:0] = ln[1] ? w[LEN-1:LEN/2]
                                                 : w[LEN/2-1:0];
      t == FOUR_BYTE: r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Lane strobes and replicated store word for the latched element
  always_comb begin
    st_strb = 4'b0000;
    st_word = '0;
    unique case (1'b1)
      type_q == ONE_BYTE: begin
        st_strb = 4'b0001 << lane;
        st_word = {4{wdata_q[BYTE_SIZE-1:0]}};
      end
      type_q == TWO_BYTE: begin
        st_strb = lane[1] ? 4'b1100 : 4'b0011;
        st_word = {2{wdata_q[2*BYTE_SIZE-1:0]}};
      end
      type_q == FOUR_BYTE: begin
        st_strb = 4'b1111;
        st_word = wdata_q;
      end
      default: begin
        st_strb = 4'b0000;
        st_word = '0;
      end
    endcase
  end

  // Line contents after a store hit: strobed bytes replaced
  always_comb begin
    merged = line;
    for (int i = 0; i < 4; i++) begin
      if (st_strb[i]) merged[BYTE_SIZE*i +: BYTE_SIZE] =
        st_word[BYTE_SIZE*i +: BYTE_SIZE];
    end
  end

  // Next-state and RAM handshake outputs
  always_comb begin
    state_d        = state_q;
    mem_data_d     = mem_data_q;
    d_cache_status = D_CACHE_WORKING;
    ram_req        = 1'b0;
    ram_we         = 1'b0;
    ram_wstrb      = 4'b0000;
    ram_wdata      = '0;
    ram_addr       = addr_q[ADDR_WIDTH-1:2];
    fill           = 1'b0;
    merge          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        d_cache_status = D_CACHE_RESTING;
        if (cache_vis_signal == D_CACHE_LOAD ||
            cache_vis_signal == D_CACHE_STORE)
          state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!type_ok) begin
          if (!store_q) mem_data_d = '0;
          state_d = S_DONE;
        end else if (store_q) begin
          state_d = S_WRITE;
        end else if (hit) begin
          mem_data_d = extract(line, type_q, lane);
          state_d    = S_DONE;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        ram_req = 1'b1;
        if (ram_ready) begin
          fill       = 1'b1;
          mem_data_d = extract(ram_rdata, type_q, lane);
          state_d    = S_DONE;
        end
      end
      S_WRITE: begin
        ram_req   = 1'b1;
        ram_we    = 1'b1;
        ram_wstrb = st_strb;
        ram_wdata = st_word;
        if (ram_ready) begin
          merge   = hit;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        d_cache_status = L_S_FINISHED;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_data = mem_data_q;

  // State, result and valid bits; reset abandons any RAM transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_data_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_data_q <= mem_data_d;
      if (fill) valid_q[idx] <= 1'b1;
    end
  end

  // Request is captured only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      type_q  <= ONE_BYTE;
      wdata_q <= '0;
      store_q <= 1'b0;
    end else if (state_q == S_IDLE &&
                 cache_vis_signal != D_CACHE_NOP) begin
      addr_q  <= mem_vis_addr;
      type_q  <= d_cache_data_type;
      wdata_q <= cache_written_data;
      store_q <= (cache_vis_signal == D_CACHE_STORE);
    end
  end

  // Line array: refill writes whole word, store hit merges lanes
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= ram_rdata;
      tag_q[idx]  <= tag;
    end else if (merge) begin
      data_q[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: vector table plus reset
// and DONE-phase corner sequences, with a scripted RAM responder.
module tb_data_cache;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] LD  = 2'b01;
  localparam logic [1:0] ST  = 2'b10;
  localparam logic [2:0] B1  = 3'b000;
  localparam logic [2:0] B2  = 3'b001;
  localparam logic [2:0] B4  = 3'b010;
  localparam logic [1:0] RESTING  = 2'b00;
  localparam logic [1:0] FINISHED = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cache_vis_signal = NOP;
  logic [16:0] mem_vis_addr = '0;
  logic [2:0]  d_cache_data_type = B1;
  logic [31:0] cache_written_data = '0;
  logic [3:0]  write_length = 4'd1;
  logic [31:0] mem_data;
  logic [1:0]  d_cache_status;
  logic        ram_req, ram_we;
  logic [14:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] last_mem = '0;

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .rst(rst),
    .cache_vis_signal(cache_vis_signal),
    .mem_vis_addr(mem_vis_addr),
    .d_cache_data_type(d_cache_data_type),
    .cache_written_data(cache_written_data),
    .write_length(write_length),
    .mem_data(mem_data),
    .d_cache_status(d_cache_status),
    .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata),
    .ram_ready(ram_ready)
  );

  typedef struct {
    logic [1:0]  op;
    logic [16:0] addr;
    logic [2:0]  typ;
    logic [31:0] wd;
    int          w;
    logic [31:0] rd;
    bit          ram;
    logic [14:0] raddr;
    logic [3:0]  strb;
    logic [31:0] wword;
    logic [31:0] mem;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [1:0] op, input logic [16:0] addr,
    input logic [2:0] typ, input logic [31:0] wd,
    input int w, input logic [31:0] rd, input bit ram,
    input logic [14:0] raddr, input logic [3:0] strb,
    input logic [31:0] wword, input logic [31:0] mem
  );
    vec_t v;
    v.op = op; v.addr = addr; v.typ = typ; v.wd = wd;
    v.w = w; v.rd = rd; v.ram = ram; v.raddr = raddr;
    v.strb = strb; v.wword = wword; v.mem = mem;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic access(input vec_t v, input int id,
                        input bit poke_done);
    int cyc, reqc, lat;
    bit fin;
    @(negedge clk);
    chk($sformatf("v%0d idle_status", id), 32'(d_cache_status),
        32'(RESTING));
    chk($sformatf("v%0d mem_hold", id), mem_data, last_mem);
    cache_vis_signal   = v.op;
    mem_vis_addr       = v.addr;
    d_cache_data_type  = v.typ;
    cache_written_data = v.wd;
    @(posedge clk);
    #1 cache_vis_signal = NOP;
    cyc = 0; reqc = 0; fin = 0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (d_cache_status == FINISHED) begin
        fin = 1;
        ram_ready = 1'b0;
      end else if (ram_req) begin
        reqc++;
        chk($sformatf("v%0d ram_we", id), 32'(ram_we),
            32'(v.op == ST));
        chk($sformatf("v%0d ram_addr", id), 32'(ram_addr),
            32'(v.raddr));
        if (v.op == ST) begin
          chk($sformatf("v%0d ram_wstrb", id), 32'(ram_wstrb),
              32'(v.strb));
          chk($sformatf("v%0d ram_wdata", id), ram_wdata, v.wword);
        end
        ram_ready = (reqc == v.w + 1);
        ram_rdata = (reqc == v.w + 1) ? v.rd : 32'h0;
      end else begin
        ram_ready = 1'b0;
      end
    end
    lat = v.ram ? 3 + v.w : 2;
    chk($sformatf("v%0d finished", id), 32'(fin), 32'd1);
    chk($sformatf("v%0d latency", id), 32'(cyc), 32'(lat));
    chk($sformatf("v%0d req_cycles", id), 32'(reqc),
        v.ram ? 32'(v.w + 1) : 32'd0);
    chk($sformatf("v%0d mem_data", id), mem_data, v.mem);
    chk($sformatf("v%0d req_low_done", id), 32'(ram_req), 32'd0);
    last_mem = v.mem;
    if (poke_done) begin
      cache_vis_signal = LD;
      mem_vis_addr     = 17'h00080;
      @(negedge clk);
      chk("done_ignores_req", 32'(d_cache_status), 32'(RESTING));
      cache_vis_signal = NOP;
    end
  endtask

  initial begin
    bit seen;
    tbl.push_back(mk(LD, 17'h040, B4, 0, 3, 32'hDEADBEEF, 1,
                     15'h010, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(LD, 17'h040, B4, 0, 0, 0, 0,
                     0, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(ST, 17'h042, B1, 32'h000000AB, 0, 0, 1,
                     15'h010, 4'b0100, 32'hABABABAB, 32'hDEADBEEF));
    tbl.push_back(mk(LD, 17'h040, B4, 0, 0, 0, 0,
                     0, 0, 0, 32'hDEABBEEF));
    tbl.push_back(mk(ST, 17'h080, B4, 32'h12345678, 1, 0, 1,
                     15'h020, 4'b1111, 32'h12345678, 32'hDEABBEEF));
    tbl.push_back(mk(LD, 17'h082, B2, 0, 0, 32'h12345678, 1,
                     15'h020, 0, 0, 32'h00001234));
    tbl.push_back(mk(LD, 17'h440, B4, 0, 2, 32'hCAFEF00D, 1,
                     15'h110, 0, 0, 32'hCAFEF00D));
    tbl.push_back(mk(LD, 17'h040, B4, 0, 0, 32'hDEABBEEF, 1,
                     15'h010, 0, 0, 32'hDEABBEEF));
    tbl.push_back(mk(LD, 17'h043, B1, 0, 0, 0, 0,
                     0, 0, 0, 32'h000000DE));
    tbl.push_back(mk(LD, 17'h041, B1, 0, 0, 0, 0,
                     0, 0, 0, 32'h000000BE));
    tbl.push_back(mk(LD, 17'h043, B2, 0, 0, 0, 0,
                     0, 0, 0, 32'h0000DEAB));
    tbl.push_back(mk(ST, 17'h043, B2, 32'hFFFF5566, 0, 0, 1,
                     15'h010, 4'b1100, 32'h55665566, 32'h0000DEAB));
    tbl.push_back(mk(LD, 17'h040, B4, 0, 0, 0, 0,
                     0, 0, 0, 32'h5566BEEF));
    tbl.push_back(mk(LD, 17'h040, 3'b111, 0, 0, 0, 0,
                     0, 0, 0, 32'h00000000));
    tbl.push_back(mk(ST, 17'h441, B1, 32'h00000011, 0, 0, 1,
                     15'h110, 4'b0010, 32'h11111111, 32'h00000000));
    tbl.push_back(mk(LD, 17'h040, B2, 0, 0, 0, 0,
                     0, 0, 0, 32'h0000BEEF));
    tbl.push_back(mk(LD, 17'h440, B4, 0, 0, 32'hCAFEF00D, 1,
                     15'h110, 0, 0, 32'hCAFEF00D));
    tbl.push_back(mk(LD, 17'h040, B4, 0, 0, 32'h5566BEEF, 1,
                     15'h010, 0, 0, 32'h5566BEEF));
    tbl.push_back(mk(LD, 17'h007, B1, 0, 0, 32'h44332211, 1,
                     15'h001, 0, 0, 32'h00000044));
    tbl.push_back(mk(LD, 17'h004, B1, 0, 0, 0, 0,
                     0, 0, 0, 32'h00000011));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_status", 32'(d_cache_status), 32'(RESTING));
    chk("rst_mem_data", mem_data, 32'h0);
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_wstrb", 32'(ram_wstrb), 32'd0);

    foreach (tbl[i]) access(tbl[i], i, i == 1);

    // Reset in the middle of a refill
    @(negedge clk);
    cache_vis_signal  = LD;
    mem_vis_addr      = 17'h840;
    d_cache_data_type = B4;
    @(posedge clk);
    #1 cache_vis_signal = NOP;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = ram_req;
    end
    chk("midrst_req_seen", 32'(seen), 32'd1);
    ram_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ram_req", 32'(ram_req), 32'd0);
    chk("midrst_status", 32'(d_cache_status), 32'(RESTING));
    chk("midrst_mem_data", mem_data, 32'h0);
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    rst = 1'b0;
    last_mem = 32'h0;

    access(mk(LD, 17'h040, B4, 0, 0, 32'h5566BEEF, 1,
              15'h010, 0, 0, 32'h5566BEEF), 100, 0);
    access(mk(LD, 17'h004, B1, 0, 1, 32'h44332211, 1,
              15'h001, 0, 0, 32'h00000011), 101, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
